byte_nibble_adder: RTL and testbench

BYTE_NIBBLE_ADDER -- requirements
Module: byte_nibble_adder

---
 rtl/byte_nibble_adder_pkg.sv | 22 ++
 rtl/byte_nibble_adder_nibble_add_ci.sv | 21 ++
 rtl/byte_nibble_adder.sv | 123 ++++++++++++
 tb/tb_byte_nibble_adder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/byte_nibble_adder_pkg.sv
// ============================================================================
// Module  : byte_nibble_adder_pkg
// Brief   : Shared state encoding and widths for the nibble-serial byte adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package byte_nibble_adder_pkg;

   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage : byte_nibble_adder_pkg

`default_nettype wire

// File: rtl/byte_nibble_adder_nibble_add_ci.sv
// ============================================================================
// Module  : nibble_add_ci
// Brief   : Combinational 4-bit adder with carry-in; q[4] is the carry-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_add_ci
   import byte_nibble_adder_pkg::*;
(
   input  logic [NIB_W-1:0] x,
   input  logic [NIB_W-1:0] y,
   input  logic             cin,
   output logic [NIB_W:0]   q
);

   assign q = {1'b0, x} + {1'b0, y} + {{NIB_W{1'b0}}, cin};

endmodule : nibble_add_ci

`default_nettype wire

// File: rtl/byte_nibble_adder.sv
// ============================================================================
// Module  : byte_nibble_adder
// Brief   : Byte add/subtract computed one nibble per cycle through a single
//           shared 4-bit adder, with valid/ready handshakes on both sides.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_nibble_adder
   import byte_nibble_adder_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W:0]   sum,
   output logic [CNT_W-1:0]  txn_cnt
);

   state_e              state_q, state_d;
   logic [BYTE_W-1:0]   a_q, a_d;
   logic [BYTE_W-1:0]   b_q, b_d;
   logic                op_q, op_d;
   logic                carry_q, carry_d;
   logic [BYTE_W:0]     sum_q, sum_d;
   logic [CNT_W-1:0]    txn_q, txn_d;

   logic [NIB_W-1:0]    nib_x;
   logic [NIB_W-1:0]    nib_y;
   logic                nib_ci;
   logic [NIB_W:0]      nib_q;

   nibble_add_ci u_nib (
      .x   (nib_x),
      .y   (nib_y),
      .cin (nib_ci),
      .q   (nib_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         txn_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         txn_q   <= txn_d;
      end
   end

   // Subtraction is a + ~b + 1: b is stored inverted and op seeds the low carry.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      txn_d   = txn_q;
      nib_x   = '0;
      nib_y   = '0;
      nib_ci  = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = op ? ~b : b;
               op_d    = op;
               state_d = LOW;
            end
         end
         LOW: begin
            nib_x                = a_q[NIB_W-1:0];
            nib_y                = b_q[NIB_W-1:0];
            nib_ci               = op_q;
            sum_d[NIB_W-1:0]     = nib_q[NIB_W-1:0];
            carry_d              = nib_q[NIB_W];
            state_d              = HIGH;
         end
         HIGH: begin
            nib_x                = a_q[BYTE_W-1:NIB_W];
            nib_y                = b_q[BYTE_W-1:NIB_W];
            nib_ci               = carry_q;
            sum_d[BYTE_W:NIB_W]  = nib_q;
            state_d              = DONE;
         end
         DONE: begin
            if (out_ready) begin
               txn_d   = txn_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign txn_cnt   = txn_q;

endmodule : byte_nibble_adder

`default_nettype wire

// File: tb/tb_byte_nibble_adder.sv
// ============================================================================
// Module  : tb_byte_nibble_adder
// Brief   : Self-checking bench: directed vector table, reset abort, counter
//           wrap on a narrow-counter instance, and randomized transactions.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_byte_nibble_adder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       op;
   logic       out_ready;

   logic       in_ready,  in_ready2;
   logic       out_valid, out_valid2;
   logic [8:0] sum,       sum2;
   logic [7:0] txn_cnt;
   logic [1:0] txn_cnt2;

   int checks   = 0;
   int failures = 0;
   int cnt      = 0;

   byte_nibble_adder #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .txn_cnt   (txn_cnt)
   );

   byte_nibble_adder #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .sum       (sum2),
      .txn_cnt   (txn_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vop;
      int         hold;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Arithmetic reference: 9-bit sum for add; for sub, low byte of a-b and a>=b flag.
   function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic o);
      int r;
      if (!o) begin
         r = int'(x) + int'(y);
         return 9'(r);
      end
      r = int'(x) - int'(y);
      return {(x >= y), 8'(r & 255)};
   endfunction

   // Called mid-cycle with DUT idle; returns mid-cycle after the handoff.
   task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb, input logic top,
                          input int hold, input logic [8:0] texp, input string nm);
      check({nm, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      a = ta; b = tb; op = top; in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check({nm, "_busy_out_valid"}, 32'(out_valid), 32'd0);
         check({nm, "_busy_in_ready"}, 32'(in_ready), 32'd0);
         out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check({nm, "_out_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_sum"}, 32'(sum), 32'(texp));
      check({nm, "_sum_w2"}, 32'(sum2), 32'(texp));
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0; in_valid = 1'b1;
         a = 8'($urandom); b = 8'($urandom);
         @(negedge clk);
         check({nm, "_hold_out_valid"}, 32'(out_valid), 32'd1);
         check({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
         check({nm, "_hold_sum"}, 32'(sum), 32'(texp));
         check({nm, "_hold_cnt"}, 32'(txn_cnt), 32'(cnt % 256));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      cnt++;
      @(negedge clk);
      check({nm, "_post_out_valid"}, 32'(out_valid), 32'd0);
      check({nm, "_post_in_ready"}, 32'(in_ready), 32'd1);
      check({nm, "_txn_cnt"}, 32'(txn_cnt), 32'(cnt % 256));
      check({nm, "_txn_cnt_w2"}, 32'(txn_cnt2), 32'(cnt % 4));
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rop;

      vecs[0] = '{va: 8'hAA, vb: 8'h55, vop: 1'b0, hold: 0, exp: 9'h0FF};
      vecs[1] = '{va: 8'hFF, vb: 8'h01, vop: 1'b0, hold: 0, exp: 9'h100};
      vecs[2] = '{va: 8'hCC, vb: 8'h33, vop: 1'b0, hold: 1, exp: 9'h0FF};
      vecs[3] = '{va: 8'h10, vb: 8'h01, vop: 1'b1, hold: 0, exp: 9'h10F};
      vecs[4] = '{va: 8'h01, vb: 8'h02, vop: 1'b1, hold: 0, exp: 9'h0FF};
      vecs[5] = '{va: 8'h80, vb: 8'h80, vop: 1'b1, hold: 5, exp: 9'h100};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].hold, vecs[i].exp,
                 $sformatf("vec%0d", i));

      // Abort in HIGH: asynchronous reset must take effect with no clock edge.
      a = 8'h5A; b = 8'h3C; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_txn_cnt", 32'(txn_cnt), 32'd0);
      check("abort_txn_cnt_w2", 32'(txn_cnt2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      run_txn(8'h5A, 8'h3C, 1'b0, 0, ref_sum(8'h5A, 8'h3C, 1'b0), "after_abort");

      for (int i = 0; i < 5; i++)
         run_txn(8'(i * 17), 8'(i * 3), 1'b0, 0, ref_sum(8'(i * 17), 8'(i * 3), 1'b0),
                 $sformatf("wrap%0d", i));

      for (int i = 0; i < 40; i++) begin
         ra  = 8'($urandom);
         rb  = (i % 8 == 0) ? ra : 8'($urandom);
         rop = 1'($urandom);
         run_txn(ra, rb, rop, int'($urandom_range(0, 2)), ref_sum(ra, rb, rop),
                 $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_byte_nibble_adder

`default_nettype wire
